core_mem_arbiter: RTL and testbench

- Shares one memory port between the core's instruction-fetch requester (port I) and its load/store requester (port D).
- Performs request arbitration and holds each request until it is granted.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to its originator.
- Sits between the fetch/LSU stages and the single external memory bus.

---
 rtl/core_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_core_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one memory bus, zero-latency request/grant, in-order response routing via ID FIFO.
// Requests are held by the FSM until granted; new requests stall while MAX_OUTSTANDING are in flight. CORE_ARB_RR_EN selects round-robin.
module core_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  inst_req_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    output logic                  inst_grnt_o,
    output logic                  inst_valid_o,
    output logic [DATA_WIDTH-1:0] inst_rdata_o,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_wen_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_grnt_o,
    output logic                  data_valid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_wen_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_grnt_i,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  err_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

    state_t           r_state;
    logic             r_ids [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic w_full, w_empty, w_idle_sel_d, w_sel_d, w_req, w_push, w_pop, w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef CORE_ARB_RR_EN
    logic r_last_d;
    // On a tie the port that did not win last time goes first.
    assign w_idle_sel_d = data_req_i & (~inst_req_i | ~r_last_d);
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            r_last_d <= 1'b1;
        else if (w_push)
            r_last_d <= w_sel_d;
    end
`else
    assign w_idle_sel_d = data_req_i;
`endif

    assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);

    always_comb begin
        w_req   = 1'b0;
        w_sel_d = 1'b0;
        case (r_state)
            IDLE: begin
                w_req   = ~w_full & (inst_req_i | data_req_i);
                w_sel_d = w_idle_sel_d;
            end
            HOLD_I: begin
                w_req   = 1'b1;
                w_sel_d = 1'b0;
            end
            HOLD_D: begin
                w_req   = 1'b1;
                w_sel_d = 1'b1;
            end
            default: begin
                w_req   = 1'b0;
                w_sel_d = 1'b0;
            end
        endcase
    end

    assign mem_req_o   = w_req;
    assign mem_addr_o  = !w_req ? '0 : (w_sel_d ? data_addr_i : inst_addr_i);
    assign mem_wen_o   = w_req & w_sel_d & data_wen_i;
    assign mem_wdata_o = (w_req & w_sel_d) ? data_wdata_i : '0;

    assign w_push      = mem_grnt_i & w_req;
    assign w_pop       = mem_valid_i & ~w_empty;
    assign w_head      = r_ids[r_rptr];

    assign inst_grnt_o  = w_push & ~w_sel_d;
    assign data_grnt_o  = w_push & w_sel_d;
    assign inst_valid_o = w_pop & ~w_head;
    assign data_valid_o = w_pop & w_head;
    assign inst_rdata_o = mem_rdata_i;
    assign data_rdata_o = mem_rdata_i;
    assign err_o        = r_err;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (w_req && !mem_grnt_i) r_state <= w_sel_d ? HOLD_D : HOLD_I;
                HOLD_I,
                HOLD_D:  if (mem_grnt_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_push) begin
                r_ids[r_wptr] <= w_sel_d;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop)
                r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A response with nothing outstanding means the bus and arbiter disagree.
            if (mem_valid_i && w_empty)
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        inst_req_i, data_req_i, data_wen_i;
    logic [31:0] inst_addr_i, data_addr_i, data_wdata_i;
    logic        inst_grnt_o, inst_valid_o, data_grnt_o, data_valid_o;
    logic [31:0] inst_rdata_o, data_rdata_o;
    logic        mem_req_o, mem_wen_o, mem_grnt_i, mem_valid_i, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    core_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_grnt_o(inst_grnt_o),
        .inst_valid_o(inst_valid_o), .inst_rdata_o(inst_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_wen_i(data_wen_i),
        .data_wdata_i(data_wdata_i), .data_grnt_o(data_grnt_o),
        .data_valid_o(data_valid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
        .mem_wdata_o(mem_wdata_o), .mem_grnt_i(mem_grnt_i), .mem_valid_i(mem_valid_i),
        .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every routed valid must match the head of the expected queue.
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1 && (inst_valid_o === 1'b1 || data_valid_o === 1'b1)) begin
            check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
            check("rsp_onehot", 32'(inst_valid_o & data_valid_o), 32'd0);
            if (exp_q.size() > 0) begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_port", 32'(data_valid_o), 32'(e.port));
                check("rsp_data", e.port ? data_rdata_o : inst_rdata_o, e.data);
            end
        end
    end

    task automatic idle_in();
        inst_req_i = 0; inst_addr_i = 0;
        data_req_i = 0; data_addr_i = 0; data_wen_i = 0; data_wdata_i = 0;
        mem_grnt_i = 0; mem_valid_i = 0; mem_rdata_i = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic respond(input bit port, input logic [31:0] d);
        exp_q.push_back('{port, d});
        mem_valid_i = 1; mem_rdata_i = d;
        @(negedge clk_i);
        next_cyc();
        mem_valid_i = 0; mem_rdata_i = 0;
    endtask

    // One granted request from a single port in IDLE.
    task automatic grant_one(input bit port, input logic [31:0] addr);
        if (port) begin data_req_i = 1; data_addr_i = addr; end
        else      begin inst_req_i = 1; inst_addr_i = addr; end
        mem_grnt_i = 1;
        @(negedge clk_i);
        check(port ? "g1_data_grnt" : "g1_inst_grnt", 32'(port ? data_grnt_o : inst_grnt_o), 32'd1);
        check("g1_addr", mem_addr_o, addr);
        next_cyc();
        idle_in();
    endtask

    initial begin
        idle_in();
        rst_n_i = 0;
        next_cyc(); next_cyc();
        rst_n_i = 1;
        @(negedge clk_i);
        check("rst_mem_req", 32'(mem_req_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_grnts", 32'({inst_grnt_o, data_grnt_o}), 0);
        check("rst_valids", 32'({inst_valid_o, data_valid_o}), 0);
        check("rst_addr", mem_addr_o, 0);
        next_cyc();

        // Single fetch, response two cycles after grant.
        inst_req_i = 1; inst_addr_i = 32'h100; mem_grnt_i = 1;
        @(negedge clk_i);
        check("fetch_grnt", 32'(inst_grnt_o), 1);
        check("fetch_data_grnt", 32'(data_grnt_o), 0);
        check("fetch_mem_req", 32'(mem_req_o), 1);
        check("fetch_addr", mem_addr_o, 32'h100);
        check("fetch_wen", 32'(mem_wen_o), 0);
        next_cyc();
        idle_in();
        next_cyc();
        exp_q.push_back('{1'b0, 32'hDEADBEEF});
        mem_valid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        check("fetch_valid", 32'(inst_valid_o), 1);
        check("fetch_no_dvalid", 32'(data_valid_o), 0);
        next_cyc();
        idle_in();

        // Contention: last grant was I, so both builds pick D first.
        inst_req_i = 1; inst_addr_i = 32'h100;
        data_req_i = 1; data_addr_i = 32'h200; data_wen_i = 1; data_wdata_i = 32'h55;
        mem_grnt_i = 1;
        @(negedge clk_i);
        check("cont_d_grnt", 32'(data_grnt_o), 1);
        check("cont_i_wait", 32'(inst_grnt_o), 0);
        check("cont_addr", mem_addr_o, 32'h200);
        check("cont_wen", 32'(mem_wen_o), 1);
        check("cont_wdata", mem_wdata_o, 32'h55);
        next_cyc();
        data_req_i = 0; data_wen_i = 0; data_wdata_i = 0;
        @(negedge clk_i);
        check("cont_i_grnt", 32'(inst_grnt_o), 1);
        check("cont_i_addr", mem_addr_o, 32'h100);
        check("cont_i_wdata", mem_wdata_o, 0);
        next_cyc();
        idle_in();
        respond(1'b1, 32'h11);
        respond(1'b0, 32'h22);

        // Hold: D request waits 3 cycles, I rises in cycle 2.
        data_req_i = 1; data_addr_i = 32'h300;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin inst_req_i = 1; inst_addr_i = 32'h100; end
            @(negedge clk_i);
            check("hold_req", 32'(mem_req_o), 1);
            check("hold_addr", mem_addr_o, 32'h300);
            check("hold_no_igrnt", 32'(inst_grnt_o), 0);
            next_cyc();
        end
        mem_grnt_i = 1;
        @(negedge clk_i);
        check("hold_d_grnt", 32'(data_grnt_o), 1);
        check("hold_i_still0", 32'(inst_grnt_o), 0);
        next_cyc();
        data_req_i = 0;
        @(negedge clk_i);
        check("hold_i_grnt", 32'(inst_grnt_o), 1);
        check("hold_i_addr", mem_addr_o, 32'h100);
        next_cyc();
        idle_in();
        respond(1'b1, 32'h33);
        respond(1'b0, 32'h44);

        // Full FIFO: two outstanding reads block a third request.
        grant_one(1'b0, 32'h104);
        grant_one(1'b1, 32'h400);
        inst_req_i = 1; inst_addr_i = 32'h108;
        @(negedge clk_i);
        check("full_no_req", 32'(mem_req_o), 0);
        next_cyc();
        exp_q.push_back('{1'b0, 32'hA1});
        mem_valid_i = 1; mem_rdata_i = 32'hA1; mem_grnt_i = 1;
        @(negedge clk_i);
        check("full_pop_no_req", 32'(mem_req_o), 0);
        check("full_pop_no_grnt", 32'(inst_grnt_o), 0);
        next_cyc();
        mem_valid_i = 0; mem_rdata_i = 0;
        @(negedge clk_i);
        check("full_freed_req", 32'(mem_req_o), 1);
        check("full_freed_grnt", 32'(inst_grnt_o), 1);
        next_cyc();
        idle_in();
        respond(1'b1, 32'hB2);
        respond(1'b0, 32'hC3);

        // Ordering: I then D granted, responses 0x1 then 0x2.
        grant_one(1'b0, 32'h100);
        grant_one(1'b1, 32'h200);
        respond(1'b0, 32'h1);
        respond(1'b1, 32'h2);

        // Contention with last grant = D: round-robin favours I.
        inst_req_i = 1; inst_addr_i = 32'h100;
        data_req_i = 1; data_addr_i = 32'h200;
        mem_grnt_i = 1;
        @(negedge clk_i);
`ifdef CORE_ARB_RR_EN
        check("rr_i_first", 32'(inst_grnt_o), 1);
        check("rr_addr", mem_addr_o, 32'h100);
        next_cyc();
        inst_req_i = 0;
        @(negedge clk_i);
        check("rr_d_second", 32'(data_grnt_o), 1);
        next_cyc();
        idle_in();
        respond(1'b0, 32'h5);
        respond(1'b1, 32'h6);
`else
        check("fp_d_first", 32'(data_grnt_o), 1);
        check("fp_addr", mem_addr_o, 32'h200);
        next_cyc();
        data_req_i = 0;
        @(negedge clk_i);
        check("fp_i_second", 32'(inst_grnt_o), 1);
        next_cyc();
        idle_in();
        respond(1'b1, 32'h6);
        respond(1'b0, 32'h5);
`endif

        // Response with empty FIFO sets sticky error.
        mem_valid_i = 1; mem_rdata_i = 32'h77;
        @(negedge clk_i);
        check("err_no_ivalid", 32'(inst_valid_o), 0);
        check("err_no_dvalid", 32'(data_valid_o), 0);
        next_cyc();
        idle_in();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("err_sticky", 32'(err_o), 1);
            next_cyc();
        end

        // Reset with one transaction outstanding discards it.
        grant_one(1'b0, 32'h100);
        rst_n_i = 0;
        next_cyc();
        rst_n_i = 1;
        @(negedge clk_i);
        check("rst2_err", 32'(err_o), 0);
        check("rst2_mem_req", 32'(mem_req_o), 0);
        next_cyc();
        mem_valid_i = 1; mem_rdata_i = 32'h88;
        @(negedge clk_i);
        check("rst2_empty_ivalid", 32'(inst_valid_o), 0);
        next_cyc();
        idle_in();
        @(negedge clk_i);
        check("rst2_err_set", 32'(err_o), 1);
        check("drain_q", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
